// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the 8x8 pong ball engine.
//   state_e        : game run state (IDLE / RUN / OVER), 2-bit encoding
//   speed_level_t  : 2-bit step-speed level (only used with BALL_MOVER_SPEEDUP_EN)
//   GRID_MAX       : largest coordinate on either axis
//   SERVE_X/Y      : ball position after reset and on every serve
//   DIR_INC/DEC    : direction-flag encoding (0 = toward 7, 1 = toward 0)
//   next_coord()   : one-cell move along an axis, saturating at 0 and GRID_MAX
// -----------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    typedef logic [1:0] speed_level_t;

    localparam logic [2:0] GRID_MAX = 3'd7;
    localparam logic [2:0] SERVE_X  = 3'd3;
    localparam logic [2:0] SERVE_Y  = 3'd1;

    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    // Move one cell; the boundary check replaces wrap-around of the 3-bit add.
    function automatic logic [2:0] next_coord(input logic [2:0] c, input logic dir);
        logic [2:0] r;
        r = c;
        if (dir == DIR_INC) begin
            if (c != GRID_MAX) r = c + 3'd1;
        end else begin
            if (c != 3'd0) r = c - 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ball_mover_step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Free-running step divider for the ball engine.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en_i         : count while high
//   clr_i        : force the divider to 0 (has priority over en_i)
//   period_i     : cycles per step (>= 1)
//   step_pulse_o : high in the cycle the divider sits at period_i-1
// -----------------------------------------------------------------------------
module step_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             step_pulse_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last;

    // ">=" rather than "==" so a period that shrinks mid-count still wraps
    // instead of running the counter all the way around.
    assign last         = (cnt_q >= (period_i - ONE));
    assign step_pulse_o = en_i & ~clr_i & last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last ? '0 : (cnt_q + ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ball_mover.sv
// -----------------------------------------------------------------------------
// ball_mover
// Ball-position engine and game run state for the 8x8 pong field.
// Advances the ball one cell per step tick using the direction flags from
// the bounce/vector logic, and tracks IDLE / RUN / OVER.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : serve request (level), honoured in IDLE and OVER
//   dir_x/dir_y : 0 = toward 7, 1 = toward 0; sampled only on step_pulse
//   endgame_in  : miss indication; ends the game on a step
//   x_pos/y_pos : registered ball position
//   step_pulse  : one-cycle strobe in the cycle the position updates
//   running     : state is RUN
//   game_over   : state is OVER
// Optional build macro BALL_MOVER_SPEEDUP_EN: every 4th up-bounce halves the
// step period (up to three times); level clears on reset and on each serve.
// -----------------------------------------------------------------------------
module ball_mover
    import pong_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dir_x,
    input  logic       dir_y,
    input  logic       endgame_in,
    output logic [2:0] x_pos,
    output logic [2:0] y_pos,
    output logic       step_pulse,
    output logic       running,
    output logic       game_over
);

    state_e           state_q, state_d;
    logic [2:0]       x_q, x_d;
    logic [2:0]       y_q, y_d;
    logic             step;
    logic             serve;
    logic [CNT_W-1:0] period;
    logic [2:0]       x_nxt;
    logic [2:0]       y_nxt;

    assign x_nxt = next_coord(x_q, dir_x);
    assign y_nxt = next_coord(y_q, dir_y);
    assign serve = (state_q != ST_RUN) && start;

`ifdef BALL_MOVER_SPEEDUP_EN
    speed_level_t level_q, level_d;
    logic [1:0]   bounce_q, bounce_d;
    logic         prev_dy_q, prev_dy_d;
    logic         up_bounce;

    assign up_bounce = step && (dir_y == DIR_DEC) && (prev_dy_q == DIR_INC);
    assign period    = CNT_W'(TICK_DIV) >> level_q;

    always_comb begin
        level_d   = level_q;
        bounce_d  = bounce_q;
        prev_dy_d = prev_dy_q;
        if (serve) begin
            level_d   = '0;
            bounce_d  = '0;
            // No previous step after a serve, so an initial upward step is
            // not treated as a bounce.
            prev_dy_d = DIR_DEC;
        end else if (step) begin
            prev_dy_d = dir_y;
            if (up_bounce) begin
                bounce_d = bounce_q + 2'd1;
                if (bounce_q == 2'd3 && level_q != 2'd3) begin
                    level_d = level_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= '0;
            bounce_q  <= '0;
            prev_dy_q <= DIR_DEC;
        end else begin
            level_q   <= level_d;
            bounce_q  <= bounce_d;
            prev_dy_q <= prev_dy_d;
        end
    end
`else
    assign period = CNT_W'(TICK_DIV);
`endif

    step_timer #(
        .CNT_W(CNT_W)
    ) u_step_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (state_q == ST_RUN),
        .clr_i       (state_q != ST_RUN),
        .period_i    (period),
        .step_pulse_o(step)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            ST_IDLE: begin
                x_d = SERVE_X;
                y_d = SERVE_Y;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (step) begin
                    // A miss freezes the ball where it is; start is ignored here.
                    if (endgame_in) begin
                        state_d = ST_OVER;
                    end else begin
                        x_d = x_nxt;
                        y_d = y_nxt;
                        if (y_nxt == GRID_MAX) state_d = ST_OVER;
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    x_d     = SERVE_X;
                    y_d     = SERVE_Y;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = SERVE_X;
                y_d     = SERVE_Y;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= SERVE_X;
            y_q     <= SERVE_Y;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign step_pulse = step;
    assign running    = (state_q == ST_RUN);
    assign game_over  = (state_q == ST_OVER);

endmodule
